// File: rtl/wb_arbiter_buffered_if.sv
// wb_arbiter_buffered_if: producer channels in, register-file write port out
interface wb_arbiter_buffered_if #(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [NUM_CH-1:0]        ch_oper;
  logic [NUM_CH-1:0]        ch_writereg;
  logic [NUM_CH*ADDR_W-1:0] ch_regdest;
  logic [NUM_CH*DATA_W-1:0] ch_wbvalue;
  logic [NUM_CH-1:0]        ch_ready;
  logic [NUM_CH-1:0]        ch_overflow;
  logic                     wb_reg_en;
  logic [ADDR_W-1:0]        wb_reg_addr;
  logic [DATA_W-1:0]        wb_reg_data;
  logic                     wb_busy;
  modport master (
    output ch_oper, ch_writereg, ch_regdest, ch_wbvalue,
    input  ch_ready, ch_overflow, wb_reg_en, wb_reg_addr, wb_reg_data, wb_busy
  );
  modport slave (
    input  ch_oper, ch_writereg, ch_regdest, ch_wbvalue,
    output ch_ready, ch_overflow, wb_reg_en, wb_reg_addr, wb_reg_data, wb_busy
  );
endinterface

// File: rtl/wb_arbiter_buffered.sv
// wb_arbiter_buffered: per-channel FIFOs feeding one registered register-file write port
module wb_arbiter_buffered #(
  parameter int NUM_CH  = 3,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int RR_MODE = 0
) (
  input logic clock,
  input logic reset,
  wb_arbiter_buffered_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(NUM_CH);
  localparam int EW = ADDR_W + DATA_W;
  logic [EW-1:0]     mem [NUM_CH][DEPTH];
  logic [PW-1:0]     rd_ptr [NUM_CH];
  logic [PW-1:0]     wr_ptr [NUM_CH];
  logic [CW-1:0]     cnt [NUM_CH];
  logic [NUM_CH-1:0] vw, full, ne, push, pop, ovf;
  logic [IW-1:0]     rr_ptr, gnt;
  logic [IW:0]       idx;
  logic              gnt_v, en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  always_comb begin
    {vw, full, ne, push} = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      vw[i]   = bus.ch_oper[i] & bus.ch_writereg[i] & (bus.ch_regdest[i*ADDR_W +: ADDR_W] != '0);
      full[i] = cnt[i] == CW'(DEPTH);
      ne[i]   = cnt[i] != '0;
      push[i] = vw[i] & ~full[i];
    end
  end
  // Fixed priority is the round-robin search with the start pinned to channel 0
  always_comb begin
    gnt_v = 1'b0;
    gnt = '0;
    idx = '0;
    pop = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (RR_MODE != 0 ? {1'b0, rr_ptr} : '0) + (IW+1)'(k);
      idx = idx >= (IW+1)'(NUM_CH) ? idx - (IW+1)'(NUM_CH) : idx;
      if (!gnt_v && ne[idx[IW-1:0]]) begin
        gnt_v = 1'b1;
        gnt = idx[IW-1:0];
      end
    end
    for (int i = 0; i < NUM_CH; i++) pop[i] = gnt_v && gnt == IW'(i);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        cnt[i] <= '0;
      end
      ovf <= '0;
      rr_ptr <= '0;
      en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) begin
          mem[i][wr_ptr[i]] <= {bus.ch_regdest[i*ADDR_W +: ADDR_W], bus.ch_wbvalue[i*DATA_W +: DATA_W]};
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
        if (vw[i] && full[i]) ovf[i] <= 1'b1;
      end
      en_q <= gnt_v;
      {addr_q, data_q} <= gnt_v ? mem[gnt][rd_ptr[gnt]] : '0;
      if (gnt_v) rr_ptr <= gnt == IW'(NUM_CH - 1) ? '0 : gnt + 1'b1;
    end
  end
  assign bus.ch_ready    = ~full;
  assign bus.ch_overflow = ovf;
  assign bus.wb_reg_en   = en_q;
  assign bus.wb_reg_addr = addr_q;
  assign bus.wb_reg_data = data_q;
  assign bus.wb_busy     = |ne | en_q;
endmodule

// File: tb/tb_wb_arbiter_buffered.sv
// tb_wb_arbiter_buffered: directed checks of fixed-priority (dut0) and round-robin (dut1) arbiters
module tb_wb_arbiter_buffered;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0;
  int n_err = 0;
  always #5 clock = ~clock;
  wb_arbiter_buffered_if #(.NUM_CH(3), .DATA_W(32), .ADDR_W(5)) a ();
  wb_arbiter_buffered_if #(.NUM_CH(3), .DATA_W(32), .ADDR_W(5)) b ();
  wb_arbiter_buffered #(.NUM_CH(3), .DEPTH(4), .DATA_W(32), .ADDR_W(5), .RR_MODE(0))
    dut0 (.clock(clock), .reset(reset), .bus(a.slave));
  wb_arbiter_buffered #(.NUM_CH(3), .DEPTH(4), .DATA_W(32), .ADDR_W(5), .RR_MODE(1))
    dut1 (.clock(clock), .reset(reset), .bus(b.slave));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic clr;
    a.ch_oper = '0; a.ch_writereg = '0; a.ch_regdest = '0; a.ch_wbvalue = '0;
    b.ch_oper = '0; b.ch_writereg = '0; b.ch_regdest = '0; b.ch_wbvalue = '0;
  endtask
  task automatic put_a(input int c, input logic wr, input logic [4:0] rd, input logic [31:0] d);
    a.ch_oper[c] = 1'b1;
    a.ch_writereg[c] = wr;
    a.ch_regdest[c*5 +: 5] = rd;
    a.ch_wbvalue[c*32 +: 32] = d;
  endtask
  task automatic put_b(input int c, input logic [4:0] rd, input logic [31:0] d);
    b.ch_oper[c] = 1'b1;
    b.ch_writereg[c] = 1'b1;
    b.ch_regdest[c*5 +: 5] = rd;
    b.ch_wbvalue[c*32 +: 32] = d;
  endtask
  task automatic wb(input string tag, input logic en, input logic [4:0] ad, input logic [31:0] d);
    chk({tag, "_en"}, a.wb_reg_en, en);
    chk({tag, "_addr"}, a.wb_reg_addr, ad);
    chk({tag, "_data"}, a.wb_reg_data, d);
  endtask
  initial begin
    clr();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      wb("idle", 1'b0, 5'd0, 32'd0);
      chk("idle_ready", a.ch_ready, 3'b111);
      chk("idle_ovf", a.ch_overflow, 3'b000);
      chk("idle_busy", a.wb_busy, 1'b0);
    end
    put_a(1, 1'b1, 5'd7, 32'hDEAD_BEEF);
    tick();
    clr();
    chk("single_n1_en", a.wb_reg_en, 1'b0);
    chk("single_n1_busy", a.wb_busy, 1'b1);
    tick();
    wb("single_n2", 1'b1, 5'd7, 32'hDEAD_BEEF);
    tick();
    wb("single_n3", 1'b0, 5'd0, 32'd0);
    chk("single_busy", a.wb_busy, 1'b0);
    put_a(0, 1'b1, 5'd1, 32'hA);
    put_a(1, 1'b1, 5'd2, 32'hB);
    put_a(2, 1'b1, 5'd3, 32'hC);
    tick();
    clr();
    chk("simul_n1_en", a.wb_reg_en, 1'b0);
    tick(); wb("simul_ch0", 1'b1, 5'd1, 32'hA);
    tick(); wb("simul_ch1", 1'b1, 5'd2, 32'hB);
    tick(); wb("simul_ch2", 1'b1, 5'd3, 32'hC);
    tick(); wb("simul_done", 1'b0, 5'd0, 32'd0);
    chk("simul_busy", a.wb_busy, 1'b0);
    for (int k = 0; k <= 10; k++) begin
      clr();
      if (k < 3) for (int c = 0; c < 3; c++) put_b(c, 5'(8 + c), 32'(c * 16 + k));
      tick();
      if (k >= 1 && k <= 9) begin
        chk("rr_en", b.wb_reg_en, 1'b1);
        chk("rr_addr", b.wb_reg_addr, 5'(8 + (k - 1) % 3));
        chk("rr_data", b.wb_reg_data, 32'(((k - 1) % 3) * 16 + (k - 1) / 3));
      end
      if (k == 10) chk("rr_idle", b.wb_reg_en, 1'b0);
    end
    for (int k = 0; k <= 12; k++) begin
      clr();
      if (k <= 5) put_a(0, 1'b1, 5'd1, 32'(100 + k));
      if (k <= 4) put_a(2, 1'b1, 5'd20, 32'(200 + k));
      tick();
      if (k >= 1 && k <= 6) wb("ovf_ch0", 1'b1, 5'd1, 32'(100 + k - 1));
      else if (k >= 7 && k <= 10) wb("ovf_ch2", 1'b1, 5'd20, 32'(200 + k - 7));
      else wb("ovf_idle", 1'b0, 5'd0, 32'd0);
      chk("ovf_ready2", a.ch_ready[2], !(k >= 3 && k <= 6));
      chk("ovf_flag", a.ch_overflow, k >= 4 ? 3'b100 : 3'b000);
    end
    put_a(0, 1'b0, 5'd9, 32'h55);
    put_a(1, 1'b1, 5'd0, 32'h66);
    tick();
    clr();
    chk("filt_busy", a.wb_busy, 1'b0);
    tick(); chk("filt_en1", a.wb_reg_en, 1'b0);
    tick(); chk("filt_en2", a.wb_reg_en, 1'b0);
    chk("filt_ovf", a.ch_overflow, 3'b100);
    put_a(0, 1'b1, 5'd1, 32'h1);
    put_a(1, 1'b1, 5'd2, 32'h2);
    put_a(2, 1'b1, 5'd3, 32'h3);
    tick();
    clr();
    chk("rst_pre_busy", a.wb_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_en", a.wb_reg_en, 1'b0);
    chk("rst_busy", a.wb_busy, 1'b0);
    chk("rst_ovf", a.ch_overflow, 3'b000);
    chk("rst_ready", a.ch_ready, 3'b111);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rst_after_en", a.wb_reg_en, 1'b0);
      chk("rst_after_busy", a.wb_busy, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
